edge_detect_irq: RTL and testbench

- Multi-channel input conditioner and interrupt source for external asynchronous inputs (pedestrian buttons, sensor contacts).
- Per channel: synchroniser chain, debouncer, edge detector with selectable mode, and a sticky pending flag cleared by software.
- Sits between the board-level inputs and the traffic-light controller / PS interrupt line.
- Supersedes the single-channel edge detector: adds channel count, metastability protection, debouncing, edge-mode selection and interrupt latching.

---
 rtl/edge_detect_irq.sv | 92 +++++++++
 tb/tb_edge_detect_irq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_irq.sv
// Multi-channel input conditioner: synchroniser, debouncer, edge detector
// and sticky per-channel pending flags feeding one registered irq line.
module edge_detect_irq #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sig,
  input  logic [2*N_CH-1:0] edge_sel,
  input  logic [N_CH-1:0]   irq_clr,
  output logic [N_CH-1:0]   sig_db,
  output logic [N_CH-1:0]   r_edge,
  output logic [N_CH-1:0]   f_edge,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   syn;
    logic                   db_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   pend_q;
    logic                   qual;

    assign syn  = sync_q[SYNC_STAGES-1];
    assign qual = (rise_q & edge_sel[2*i])
                | (fall_q & edge_sel[2*i+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig[i]};
      end
    end

    // Edge pulses are registered alongside the debounced level update.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (syn == db_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          db_q   <= syn;
          rise_q <= syn;
          fall_q <= ~syn;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end

    // Set beats clear so an edge coinciding with a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= qual | (pend_q & ~irq_clr[i]);
      end
    end

    assign sig_db[i]  = db_q;
    assign r_edge[i]  = rise_q;
    assign f_edge[i]  = fall_q;
    assign pending[i] = pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |pending;
    end
  end

endmodule

// File: tb/tb_edge_detect_irq.sv
// Bench for edge_detect_irq: directed scenarios plus random traffic
// checked every cycle against a window-based behavioural model.
module tb_edge_detect_irq;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   sig;
  logic [2*N-1:0] edge_sel;
  logic [N-1:0]   irq_clr;
  logic [N-1:0]   sig_db;
  logic [N-1:0]   r_edge;
  logic [N-1:0]   f_edge;
  logic [N-1:0]   pending;
  logic           irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edge_detect_irq #(
    .N_CH(N),
    .SYNC_STAGES(S),
    .DEB_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig(sig),
    .edge_sel(edge_sel),
    .irq_clr(irq_clr),
    .sig_db(sig_db),
    .r_edge(r_edge),
    .f_edge(f_edge),
    .pending(pending),
    .irq(irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: sig history as a delay line; the debounced level flips once
  // the last D synchronised samples all disagree with it.
  bit [N-1:0] m_db;
  bit [N-1:0] m_r;
  bit [N-1:0] m_f;
  bit [N-1:0] m_pend;
  bit         m_irq;
  bit         line [N][S];
  bit         win  [N][D];

  task automatic model_reset();
    m_db = '0; m_r = '0; m_f = '0; m_pend = '0; m_irq = 1'b0;
    for (int c = 0; c < N; c++) begin
      for (int s = 0; s < S; s++) line[c][s] = 1'b0;
      for (int d = 0; d < D; d++) win[c][d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit [N-1:0] n_db, n_r, n_f, n_pend;
    bit         all_diff;
    n_db = m_db; n_r = '0; n_f = '0;
    for (int c = 0; c < N; c++) begin
      n_pend[c] = (m_r[c] & edge_sel[2*c]) | (m_f[c] & edge_sel[2*c+1])
                | (m_pend[c] & ~irq_clr[c]);
      for (int d = D - 1; d > 0; d--) win[c][d] = win[c][d-1];
      win[c][0] = line[c][S-1];
      all_diff = 1'b1;
      for (int d = 0; d < D; d++)
        if (win[c][d] == m_db[c]) all_diff = 1'b0;
      if (all_diff) begin
        n_db[c] = ~m_db[c];
        n_r[c]  = ~m_db[c];
        n_f[c]  = m_db[c];
      end
      for (int s = S - 1; s > 0; s--) line[c][s] = line[c][s-1];
      line[c][0] = sig[c];
    end
    m_irq  = |m_pend;
    m_db   = n_db; m_r = n_r; m_f = n_f; m_pend = n_pend;
  endtask

  task automatic compare();
    check("sig_db", 32'(sig_db), 32'(m_db));
    check("r_edge", 32'(r_edge), 32'(m_r));
    check("f_edge", 32'(f_edge), 32'(m_f));
    check("pending", 32'(pending), 32'(m_pend));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare();
  endtask

  task automatic clear_all();
    irq_clr = '1;
    step();
    irq_clr = '0;
    step();
  endtask

  int r_at, p_at, i_at, r_cnt, f_cnt, n;

  initial begin
    rst_n = 1'b0; sig = '0; edge_sel = 8'b0000_0001; irq_clr = '0;
    model_reset();
    #1;
    check("reset_db", 32'(sig_db), 0);
    check("reset_pend", 32'(pending), 0);
    check("reset_irq", 32'(irq), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();

    // 1: latency of a clean rising step on channel 0
    sig[0] = 1'b1;
    r_at = -1; p_at = -1; i_at = -1; r_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (r_edge[0]) r_cnt++;
      if (r_edge[0] && r_at < 0) r_at = k;
      if (pending[0] && p_at < 0) p_at = k;
      if (irq && i_at < 0) i_at = k;
    end
    check("t1_redge_edge", 32'(r_at), 6);
    check("t1_redge_width", 32'(r_cnt), 1);
    check("t1_pend_edge", 32'(p_at), 7);
    check("t1_irq_edge", 32'(i_at), 8);
    clear_all();

    // 2: 3-cycle glitch is swallowed, 4-cycle pulse gets through
    sig[1] = 1'b1;
    repeat (3) step();
    sig[1] = 1'b0;
    r_cnt = 0; f_cnt = 0;
    repeat (12) begin
      step();
      r_cnt += int'(r_edge[1]); f_cnt += int'(f_edge[1]);
    end
    check("t2_glitch_r", 32'(r_cnt), 0);
    check("t2_glitch_f", 32'(f_cnt), 0);
    check("t2_glitch_db", 32'(sig_db[1]), 0);
    sig[1] = 1'b1;
    r_cnt = 0; f_cnt = 0;
    repeat (4) begin
      step();
      r_cnt += int'(r_edge[1]); f_cnt += int'(f_edge[1]);
    end
    sig[1] = 1'b0;
    repeat (16) begin
      step();
      r_cnt += int'(r_edge[1]); f_cnt += int'(f_edge[1]);
    end
    check("t2_pulse_r", 32'(r_cnt), 1);
    check("t2_pulse_f", 32'(f_cnt), 1);

    // 3: edge modes on channel 2
    edge_sel = '0;
    clear_all();
    sig[2] = 1'b1; r_cnt = 0;
    repeat (10) begin step(); r_cnt += int'(r_edge[2]); end
    sig[2] = 1'b0; f_cnt = 0;
    repeat (10) begin step(); f_cnt += int'(f_edge[2]); end
    check("t3_none_r", 32'(r_cnt), 1);
    check("t3_none_f", 32'(f_cnt), 1);
    check("t3_none_pend", 32'(pending[2]), 0);
    edge_sel[5:4] = 2'b10;
    sig[2] = 1'b1; repeat (10) step();
    check("t3_fall_rise", 32'(pending[2]), 0);
    sig[2] = 1'b0; repeat (10) step();
    check("t3_fall_fall", 32'(pending[2]), 1);
    clear_all();
    edge_sel[5:4] = 2'b11;
    sig[2] = 1'b1; repeat (10) step();
    check("t3_both_rise", 32'(pending[2]), 1);
    clear_all();
    sig[2] = 1'b0; repeat (10) step();
    check("t3_both_fall", 32'(pending[2]), 1);
    clear_all();

    // 4: clear racing a qualifying edge on channel 3
    edge_sel = 8'b0100_0000;
    sig[3] = 1'b1; repeat (10) step();
    check("t4_set", 32'(pending[3]), 1);
    sig[3] = 1'b0; repeat (10) step();
    check("t4_hold", 32'(pending[3]), 1);
    sig[3] = 1'b1;
    n = 0;
    while (!r_edge[3] && n < 12) begin step(); n++; end
    check("t4_edge_seen", 32'(r_edge[3]), 1);
    irq_clr[3] = 1'b1; step(); irq_clr[3] = 1'b0;
    check("t4_race_pend", 32'(pending[3]), 1);
    irq_clr[3] = 1'b1; step(); irq_clr[3] = 1'b0;
    check("t4_clr_pend", 32'(pending[3]), 0);
    check("t4_irq_lag", 32'(irq), 1);
    step();
    check("t4_irq_low", 32'(irq), 0);

    // 5: irq stays up until every channel is cleared
    edge_sel = '1;
    sig = sig ^ 4'b0101;
    repeat (10) step();
    check("t5_pend", 32'(pending), 32'h5);
    irq_clr = 4'b0001; step(); irq_clr = '0;
    repeat (3) begin step(); check("t5_irq_hold", 32'(irq), 1); end
    irq_clr = 4'b0100; step(); irq_clr = '0;
    check("t5_pend_zero", 32'(pending), 0);
    check("t5_irq_lag", 32'(irq), 1);
    step();
    check("t5_irq_low", 32'(irq), 0);

    // 6: reset in the middle of a debounce count
    sig = '0; repeat (10) step();
    edge_sel = 8'b0000_0001;
    clear_all();
    sig[0] = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_db", 32'(sig_db), 0);
    check("t6_rst_r", 32'(r_edge), 0);
    step(); step();
    check("t6_rst_db2", 32'(sig_db), 0);
    rst_n = 1'b1;
    r_at = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (r_edge[0] && r_at < 0) r_at = k;
    end
    check("t6_redge_edge", 32'(r_at), 6);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(7) == 0) sig[c] = ~sig[c];
      if ($urandom_range(49) == 0) edge_sel = 8'($urandom);
      irq_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if ((r_edge & f_edge) != '0) begin
      failures++;
      $display("FAIL both_edges got=%0h exp=0", r_edge & f_edge);
    end
  end

endmodule
